// File: rtl/clint_if.sv
// Request/response bus between the core's uncached data path and the CLINT.
// Latency: none (bundle of wires only).
// Backpressure: requester holds req_* until req_ready; responder holds resp_* until resp_ready.
// Ports: master = requester side (drives req_*, resp_ready); slave = CLINT side.
interface clint_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime / mtimecmp / msip registers, timer and software interrupts.
// Latency: response one cycle after accept; clint_mtip lags register changes by one cycle.
// Backpressure: one outstanding request; req_ready low while a response waits for resp_ready.
// Ports: clk, rst (sync, active-high); bus (clint_if.slave); clint_mtip, clint_msip, mtime_o.
module clint_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  clint_if.slave      bus,
  output logic        clint_mtip,
  output logic        clint_msip,
  output logic [63:0] mtime_o
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [63:0] OFS_MSIP     = 64'h0000;
  localparam logic [63:0] OFS_MTIMECMP = 64'h4000;
  localparam logic [63:0] OFS_MTIME    = 64'hBFF8;

  typedef enum logic {IDLE, RESP} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          mtip_q, mtip_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          tick;
  logic          accept;
  logic          wr_ok;
  logic [63:0]   offset;
  logic          sel_msip, sel_cmp, sel_mtime;
  logic          addr_err;
  logic [63:0]   wmask;
  logic [63:0]   mtime_inc;
  logic [63:0]   rd_mux;

  // Address decode. Addresses below BASE_ADDR wrap to a huge offset and decode as errors.
  always_comb begin
    offset    = bus.req_addr - BASE_ADDR;
    sel_msip  = (offset == OFS_MSIP);
    sel_cmp   = (offset == OFS_MTIMECMP);
    sel_mtime = (offset == OFS_MTIME);
    addr_err  = (bus.req_addr[2:0] != 3'b000) || !(sel_msip || sel_cmp || sel_mtime);
    for (int i = 0; i < 8; i++) begin
      wmask[i*8 +: 8] = {8{bus.req_wstrb[i]}};
    end
  end

  always_comb begin
    rd_mux = 64'h0;
    if (sel_msip)  rd_mux = {63'h0, msip_q};
    if (sel_cmp)   rd_mux = mtimecmp_q;
    if (sel_mtime) rd_mux = mtime_q;
  end

  assign tick      = (presc_q == PRESC_MAX);
  assign mtime_inc = tick ? (mtime_q + 64'h1) : mtime_q;
  assign accept    = (state_q == IDLE) && bus.req_valid;
  assign wr_ok     = accept && bus.req_we && !addr_err;

  // Next-state: prescaler, timer registers, FSM and latched response.
  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    // A write to mtime overrides only the enabled bytes of the incremented value.
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    mtip_d     = (mtime_q >= mtimecmp_q);
    state_d    = state_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    if (wr_ok && sel_mtime) begin
      mtime_d = (mtime_inc & ~wmask) | (bus.req_wdata & wmask);
    end
    if (wr_ok && sel_cmp) begin
      mtimecmp_d = (mtimecmp_q & ~wmask) | (bus.req_wdata & wmask);
    end
    if (wr_ok && sel_msip && bus.req_wstrb[0]) begin
      msip_d = bus.req_wdata[0];
    end

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = RESP;
          err_d   = addr_err;
          // Reads return the value before any update committed at this same edge.
          rdata_d = (!addr_err && !bus.req_we) ? rd_mux : 64'h0;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          rdata_d = 64'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      rdata_q    <= 64'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign clint_mtip     = mtip_q;
  assign clint_msip     = msip_q;
  assign mtime_o        = mtime_q;

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor for the single-hart CPU.
- Holds the memory-mapped machine timer (mtime), timer compare (mtimecmp) and software-interrupt (msip) registers.
- Drives clint_mtip and clint_msip into the CSR/trap logic.
- Sits on the core's uncached data-bus path as a memory-mapped responder with a one-outstanding request/response handshake.

Parameters:
- BASE_ADDR, 64'h0000_0000_0200_0000, base of the CLINT region.
- TICK_DIV, 1, clk cycles per mtime increment (>=1).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1=write, 0=read
- req_addr  input  64  byte address
- req_wdata  input  64  write data
- req_wstrb  input  8  byte enables for writes
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts response
- resp_rdata  output  64  read data (0 for writes and errors)
- resp_err  output  1  access error
- clint_mtip  output  1  machine timer interrupt pending
- clint_msip  output  1  machine software interrupt pending
- mtime_o  output  64  current mtime, for difftest/debug

Behaviour:
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - clint_mtip=0, clint_msip=0.
  - FSM=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Register map (offset from BASE_ADDR):
  - 0x0000 msip: bit0 only, upper bits read 0.
  - 0x4000 mtimecmp.
  - 0xBFF8 mtime.
  - Any other address, or addr[2:0]!=0, is an error.
- Prescaler:
  - Counts 0..TICK_DIV-1 every cycle.
  - tick=1 in the cycle it equals TICK_DIV-1, then it wraps to 0.
  - TICK_DIV=1 gives a tick every cycle.
  - mtime <= mtime+1 on tick; wraps 2^64-1 -> 0 silently.
- FSM states IDLE and RESP:
  - IDLE: req_ready=1. On req_valid, accept the request, latch the response, go to RESP.
  - RESP: req_ready=0, resp_valid=1. Hold resp_rdata/resp_err stable until resp_ready=1, then go to IDLE.
  - resp_valid & resp_ready returns to IDLE the next cycle. No back-to-back accept in the completing cycle; minimum request-to-request spacing is 2 cycles.
- Reads:
  - resp_rdata is the register value in the accept cycle, i.e. the pre-update value.
  - Errors return resp_rdata=0, resp_err=1.
- Writes:
  - Committed at the accept edge, per byte under req_wstrb: new = (old & ~mask) | (wdata & mask).
  - msip uses wstrb[0] bit0 only.
  - Errored writes change no state and return resp_err=1.
  - wstrb=0 is a legal no-op write with resp_err=0.
- Simultaneous mtime write and tick: the write wins for the enabled bytes. Bytes not enabled take the incremented value's bytes. The prescaler is not reset by the write.
- clint_mtip: registered each cycle as (mtime >= mtimecmp), unsigned, using current register values. It therefore lags any mtime/mtimecmp change by exactly one cycle. It is level; it is cleared only by making mtimecmp > mtime.
- clint_msip: equals the msip register bit (registered, no extra lag).
- mtime_o: equals the mtime register.
- Reset mid-transaction: the FSM returns to IDLE and drops the pending response (resp_valid=0 the cycle after rst). All registers return to reset values.
- req_* inputs are ignored in RESP. The requester holds them until req_ready is seen.

Test Plan:
- Reset with TICK_DIV=1 -> clint_mtip=0, clint_msip=0, mtime_o=0. Read mtimecmp -> 64'hFFFF_FFFF_FFFF_FFFF with resp_err=0. req_ready=1 the first cycle after reset.
- TICK_DIV=4, 40 idle cycles after reset -> mtime_o=10. Each increment is exactly 4 cycles apart.
- Write mtimecmp=20 (wstrb=8'hFF) with TICK_DIV=1 -> clint_mtip rises exactly 1 cycle after mtime_o reaches 20. A later mtimecmp=64'hFFFF_FFFF_FFFF_FFFF write drops it 1 cycle after the write edge.
- Write mtime=64'h1122_3344_5566_7788 with wstrb=8'h0F in a tick cycle while mtime=0x100 -> mtime=64'h0000_0000_5566_7788 at the edge; the increment on bytes 4-7 yields 0.
- Read BASE+0x1000, then write BASE+0xBFFC -> both give resp_err=1, rdata=0, and no state change.
- Write msip=1, read it back holding resp_ready=0 for 5 cycles -> resp_valid and resp_rdata=1 are held stable and req_ready=0 throughout. clint_msip=1. Asserting rst while resp_valid=1 clears resp_valid and clint_msip next cycle.
